// File: rtl/prog_counter.sv
// Program counter and fetch sequencer for the instruction ROM.
// IDLE -> RUN on start; RUN -> HALTED on halt request; HALTED -> RUN on start.
//
// Ports:
//   clk_i            sole clock, rising edge
//   reset_i          asynchronous active-high reset
//   start_i          begin fetching at start_addr_i (IDLE/HALTED only)
//   start_addr_i     first fetch address
//   stall_i          hold the current address this cycle
//   jump_i           load jump_target_i next cycle
//   jump_target_i    absolute jump address
//   branch_i         add sign-extended branch_offset_i next cycle
//   branch_offset_i  signed 8-bit relative offset
//   halt_req_i       stop fetching and enter HALTED
//   inst_address_o   registered ROM address (straight from the PC register)
//   fetch_valid_o    inst_address_o is consumed this cycle
//   done_o           high while HALTED
//   cycle_count_o    saturating count of RUN cycles since the last start
module prog_counter #(
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [AW-1:0] start_addr_i,
    input  logic          stall_i,
    input  logic          jump_i,
    input  logic [AW-1:0] jump_target_i,
    input  logic          branch_i,
    input  logic [7:0]    branch_offset_i,
    input  logic          halt_req_i,
    output logic [AW-1:0] inst_address_o,
    output logic          fetch_valid_o,
    output logic          done_o,
    output logic [15:0]   cycle_count_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   cnt_q, cnt_d;

    // Sign-extend the offset to AW bits; the sum then wraps modulo 2**AW.
    logic [AW-1:0] off_ext;
    assign off_ext = AW'($signed(branch_offset_i));

    logic [15:0] cnt_inc;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = start_addr_i;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // Stalled and halting cycles still count as RUN cycles.
                cnt_d = cnt_inc;
                if (halt_req_i) begin
                    state_d = S_HALTED;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (jump_i) begin
                    pc_d = jump_target_i;
                end else if (branch_i) begin
                    pc_d = pc_q + off_ext;
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign inst_address_o = pc_q;
    assign fetch_valid_o  = (state_q == S_RUN) && !stall_i;
    assign done_o         = (state_q == S_HALTED);
    assign cycle_count_o  = cnt_q;

endmodule
